ex_stage: RTL and testbench

- Execute stage of the 5-stage MIPS datapath. Consumes the ID/EX pipeline register outputs and applies EX/MEM forwarding muxes.
- Computes the ALU result, including an iterative 32-cycle shift-add multiply that stalls upstream.
- Registers everything the memory stage needs into an internal EX/MEM register.
- A downstream MEM stage reads the *Out ports directly.

---
 rtl/ex_stage.sv | 245 ++++++++++++++++++++++++
 tb/tb_ex_stage.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_stage.sv
// rtl/ex_stage.sv - MIPS execute stage with forwarding, ALU, iterative multiply and EX/MEM register
//
// Purpose:
//   Selects forwarded operands, computes the ALU result and registers it together
//   with the memory-stage controls into the EX/MEM register. Opcode 11 (MUL) runs a
//   32-iteration shift-add multiply that holds the upstream pipeline via stall.
//
// Ports:
//   clock, reset        pipeline clock; asynchronous active-high reset
//   syncClr             synchronous flush of EX/MEM, aborts a multiply
//   aluOperation        ALU opcode
//   sigExt              sign-extended immediate
//   readData1/2         rs / rt register values
//   rt, rd, sa          instruction fields
//   aluSrc              operand B from sigExt
//   aluShiftImm         shift amount from sa instead of operand A[4:0]
//   regDst              destination is rd instead of rt
//   loadImm             LUI: result = {sigExt[15:0], 16'h0}
//   memWrite, memToReg, memReadWidth, regWrite   control passthroughs
//   fwdA, fwdB          forwarding selects (1 = memFwdData, 2 = wbFwdData)
//   memFwdData, wbFwdData  forwarded results
//   stall               combinational upstream hold request
//   *Out                registered EX/MEM outputs

module ex_stage #(
  parameter int MUL_ENABLE = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        syncClr,
  input  logic [3:0]  aluOperation,
  input  logic [31:0] sigExt,
  input  logic [31:0] readData1,
  input  logic [31:0] readData2,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [4:0]  sa,
  input  logic        aluSrc,
  input  logic        aluShiftImm,
  input  logic        regDst,
  input  logic        loadImm,
  input  logic [3:0]  memWrite,
  input  logic        memToReg,
  input  logic [1:0]  memReadWidth,
  input  logic        regWrite,
  input  logic [1:0]  fwdA,
  input  logic [1:0]  fwdB,
  input  logic [31:0] memFwdData,
  input  logic [31:0] wbFwdData,
  output logic        stall,
  output logic [31:0] aluResultOut,
  output logic [31:0] writeDataOut,
  output logic [4:0]  writeRegOut,
  output logic [3:0]  memWriteOut,
  output logic        memToRegOut,
  output logic [1:0]  memReadWidthOut,
  output logic        regWriteOut
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mul_state_t;

  mul_state_t  state_q, state_d;
  logic [31:0] mcand_q, mcand_d;
  logic [31:0] mplier_q, mplier_d;
  logic [31:0] acc_q, acc_d;
  logic [4:0]  cnt_q, cnt_d;

  logic [31:0] result_q, result_d;
  logic [31:0] wdata_q, wdata_d;
  logic [4:0]  wreg_q, wreg_d;
  logic [3:0]  mem_write_q, mem_write_d;
  logic        mem_to_reg_q, mem_to_reg_d;
  logic [1:0]  mem_rd_width_q, mem_rd_width_d;
  logic        reg_write_q, reg_write_d;

  logic [31:0] fa, fb, alu_b, alu_res;
  logic [4:0]  shamt;
  logic        start_mul;

  // Operand selection
  always_comb begin
    case (fwdA)
      2'd1:    fa = memFwdData;
      2'd2:    fa = wbFwdData;
      default: fa = readData1;
    endcase
    case (fwdB)
      2'd1:    fb = memFwdData;
      2'd2:    fb = wbFwdData;
      default: fb = readData2;
    endcase
    alu_b = aluSrc ? sigExt : fb;
    shamt = aluShiftImm ? sa : fa[4:0];
  end

  // Single-cycle ALU; MUL yields 0 here, the multiplier result comes from acc_q
  always_comb begin
    alu_res = 32'h0;
    if (loadImm) begin
      alu_res = {sigExt[15:0], 16'h0};
    end else begin
      case (aluOperation)
        4'd0:    alu_res = alu_b << shamt;
        4'd1:    alu_res = alu_b >> shamt;
        4'd2:    alu_res = $signed(alu_b) >>> shamt;
        4'd3:    alu_res = fa + alu_b;
        4'd4:    alu_res = fa - alu_b;
        4'd5:    alu_res = fa & alu_b;
        4'd6:    alu_res = fa | alu_b;
        4'd7:    alu_res = fa ^ alu_b;
        4'd8:    alu_res = ~(fa | alu_b);
        4'd9:    alu_res = {31'h0, ($signed(fa) < $signed(alu_b))};
        4'd10:   alu_res = {31'h0, (fa < alu_b)};
        default: alu_res = 32'h0;
      endcase
    end
  end

  // LUI takes precedence over the opcode, so it never launches a multiply
  assign start_mul = (MUL_ENABLE != 0) && (aluOperation == 4'd11) && !loadImm;

  // Stall is dropped at once by reset or flush so upstream never waits on an aborted multiply
  always_comb begin
    stall = 1'b0;
    if (!reset && !syncClr) begin
      case (state_q)
        IDLE:    stall = start_mul;
        BUSY:    stall = 1'b1;
        default: stall = 1'b0;
      endcase
    end
  end

  // Multiplier FSM
  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    if (syncClr) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_mul) begin
            mcand_d  = fa;
            mplier_d = alu_b;
            acc_d    = 32'h0;
            cnt_d    = 5'd0;
            state_d  = BUSY;
          end
        end
        BUSY: begin
          if (mplier_q[0]) begin
            acc_d = acc_q + mcand_q;
          end
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            state_d = DONE;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // EX/MEM next state: flush, bubble while stalled, otherwise load
  always_comb begin
    result_d       = result_q;
    wdata_d        = wdata_q;
    wreg_d         = wreg_q;
    mem_write_d    = mem_write_q;
    mem_to_reg_d   = mem_to_reg_q;
    mem_rd_width_d = mem_rd_width_q;
    reg_write_d    = reg_write_q;
    if (syncClr) begin
      result_d       = 32'h0;
      wdata_d        = 32'h0;
      wreg_d         = 5'd0;
      mem_write_d    = 4'h0;
      mem_to_reg_d   = 1'b0;
      mem_rd_width_d = 2'd0;
      reg_write_d    = 1'b0;
    end else if (stall) begin
      mem_write_d  = 4'h0;
      mem_to_reg_d = 1'b0;
      reg_write_d  = 1'b0;
    end else begin
      result_d       = (state_q == DONE) ? acc_q : alu_res;
      wdata_d        = fb;
      wreg_d         = regDst ? rd : rt;
      mem_write_d    = memWrite;
      mem_to_reg_d   = memToReg;
      mem_rd_width_d = memReadWidth;
      reg_write_d    = regWrite;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      mcand_q        <= 32'h0;
      mplier_q       <= 32'h0;
      acc_q          <= 32'h0;
      cnt_q          <= 5'd0;
      result_q       <= 32'h0;
      wdata_q        <= 32'h0;
      wreg_q         <= 5'd0;
      mem_write_q    <= 4'h0;
      mem_to_reg_q   <= 1'b0;
      mem_rd_width_q <= 2'd0;
      reg_write_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      mcand_q        <= mcand_d;
      mplier_q       <= mplier_d;
      acc_q          <= acc_d;
      cnt_q          <= cnt_d;
      result_q       <= result_d;
      wdata_q        <= wdata_d;
      wreg_q         <= wreg_d;
      mem_write_q    <= mem_write_d;
      mem_to_reg_q   <= mem_to_reg_d;
      mem_rd_width_q <= mem_rd_width_d;
      reg_write_q    <= reg_write_d;
    end
  end

  assign aluResultOut    = result_q;
  assign writeDataOut    = wdata_q;
  assign writeRegOut     = wreg_q;
  assign memWriteOut     = mem_write_q;
  assign memToRegOut     = mem_to_reg_q;
  assign memReadWidthOut = mem_rd_width_q;
  assign regWriteOut     = reg_write_q;

endmodule

// File: tb/tb_ex_stage.sv
// tb/tb_ex_stage.sv - scoreboard testbench for ex_stage

module tb_ex_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic        syncClr;
  logic [3:0]  aluOperation;
  logic [31:0] sigExt, readData1, readData2, memFwdData, wbFwdData;
  logic [4:0]  rt, rd, sa;
  logic        aluSrc, aluShiftImm, regDst, loadImm, memToReg, regWrite;
  logic [3:0]  memWrite;
  logic [1:0]  memReadWidth, fwdA, fwdB;

  logic        stall, memToRegOut, regWriteOut;
  logic [31:0] aluResultOut, writeDataOut;
  logic [4:0]  writeRegOut;
  logic [3:0]  memWriteOut;
  logic [1:0]  memReadWidthOut;

  logic        stall0, memToRegOut0, regWriteOut0;
  logic [31:0] aluResultOut0, writeDataOut0;
  logic [4:0]  writeRegOut0;
  logic [3:0]  memWriteOut0;
  logic [1:0]  memReadWidthOut0;

  ex_stage #(.MUL_ENABLE(1)) dut (
    .clock(clock), .reset(reset), .syncClr(syncClr), .aluOperation(aluOperation),
    .sigExt(sigExt), .readData1(readData1), .readData2(readData2),
    .rt(rt), .rd(rd), .sa(sa), .aluSrc(aluSrc), .aluShiftImm(aluShiftImm),
    .regDst(regDst), .loadImm(loadImm), .memWrite(memWrite), .memToReg(memToReg),
    .memReadWidth(memReadWidth), .regWrite(regWrite), .fwdA(fwdA), .fwdB(fwdB),
    .memFwdData(memFwdData), .wbFwdData(wbFwdData), .stall(stall),
    .aluResultOut(aluResultOut), .writeDataOut(writeDataOut), .writeRegOut(writeRegOut),
    .memWriteOut(memWriteOut), .memToRegOut(memToRegOut),
    .memReadWidthOut(memReadWidthOut), .regWriteOut(regWriteOut)
  );

  ex_stage #(.MUL_ENABLE(0)) dut0 (
    .clock(clock), .reset(reset), .syncClr(syncClr), .aluOperation(aluOperation),
    .sigExt(sigExt), .readData1(readData1), .readData2(readData2),
    .rt(rt), .rd(rd), .sa(sa), .aluSrc(aluSrc), .aluShiftImm(aluShiftImm),
    .regDst(regDst), .loadImm(loadImm), .memWrite(memWrite), .memToReg(memToReg),
    .memReadWidth(memReadWidth), .regWrite(regWrite), .fwdA(fwdA), .fwdB(fwdB),
    .memFwdData(memFwdData), .wbFwdData(wbFwdData), .stall(stall0),
    .aluResultOut(aluResultOut0), .writeDataOut(writeDataOut0), .writeRegOut(writeRegOut0),
    .memWriteOut(memWriteOut0), .memToRegOut(memToRegOut0),
    .memReadWidthOut(memReadWidthOut0), .regWriteOut(regWriteOut0)
  );

  always #5 clock = ~clock;

  localparam int K_RES = 0, K_WDATA = 1, K_WREG = 2, K_RW = 3, K_MW = 4,
                 K_MTR = 5, K_MRW = 6, K_STALL = 7, K_STALL0 = 8, K_RES0 = 9;

  typedef struct {
    int          cyc;
    int          kind;
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [31:0] act_of(int k);
    case (k)
      K_RES:    return aluResultOut;
      K_WDATA:  return writeDataOut;
      K_WREG:   return {27'h0, writeRegOut};
      K_RW:     return {31'h0, regWriteOut};
      K_MW:     return {28'h0, memWriteOut};
      K_MTR:    return {31'h0, memToRegOut};
      K_MRW:    return {30'h0, memReadWidthOut};
      K_STALL:  return {31'h0, stall};
      K_STALL0: return {31'h0, stall0};
      default:  return aluResultOut0;
    endcase
  endfunction

  // Monitor: compares every expectation tagged with the current cycle
  always @(negedge clock) begin
    logic [31:0] act;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc <= cyc) begin
        checks++;
        if (sb[i].cyc < cyc) begin
          errors++;
          $display("FAIL %s cyc %0d missed (expected at cyc %0d)", sb[i].name, cyc, sb[i].cyc);
        end else begin
          act = act_of(sb[i].kind);
          if (act !== sb[i].val) begin
            errors++;
            $display("FAIL %s cyc %0d got %h want %h", sb[i].name, cyc, act, sb[i].val);
          end
        end
        sb.delete(i);
      end
    end
  end

  task automatic expect_at(input int c, input int k, input logic [31:0] v, input string nm);
    exp_t e;
    e.cyc = c; e.kind = k; e.val = v; e.name = nm;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic nop();
    aluOperation = 4'd0; sigExt = 32'h0; readData1 = 32'h0; readData2 = 32'h0;
    rt = 5'd0; rd = 5'd0; sa = 5'd0; aluSrc = 1'b0; aluShiftImm = 1'b0; regDst = 1'b0;
    loadImm = 1'b0; memWrite = 4'h0; memToReg = 1'b0; memReadWidth = 2'd0; regWrite = 1'b0;
    fwdA = 2'd0; fwdB = 2'd0; memFwdData = 32'h0; wbFwdData = 32'h0;
  endtask

  int k;

  initial begin
    reset = 1'b1;
    syncClr = 1'b0;
    nop();
    step();
    expect_at(cyc, K_RES, 32'h0, "reset_res");
    expect_at(cyc, K_WDATA, 32'h0, "reset_wdata");
    expect_at(cyc, K_WREG, 32'h0, "reset_wreg");
    expect_at(cyc, K_RW, 32'h0, "reset_rw");
    expect_at(cyc, K_STALL, 32'h0, "reset_stall");
    step();
    reset = 1'b0;

    // ADD with forwarded A
    nop(); aluOperation = 4'd3; fwdA = 2'd1; memFwdData = 32'h10; readData2 = 32'h5;
    regDst = 1'b1; rd = 5'd7; rt = 5'd3; regWrite = 1'b1; memReadWidth = 2'd2; memToReg = 1'b1;
    expect_at(cyc, K_STALL, 32'h0, "add_stall");
    expect_at(cyc + 1, K_RES, 32'h15, "add_res");
    expect_at(cyc + 1, K_WREG, 32'd7, "add_wreg");
    expect_at(cyc + 1, K_WDATA, 32'h5, "add_wdata");
    expect_at(cyc + 1, K_RW, 32'h1, "add_rw");
    expect_at(cyc + 1, K_MRW, 32'h2, "add_mrw");
    expect_at(cyc + 1, K_MTR, 32'h1, "add_mtr");
    step();

    nop(); aluOperation = 4'd2; aluShiftImm = 1'b1; sa = 5'd4; readData2 = 32'h80000000; rt = 5'd9;
    expect_at(cyc + 1, K_RES, 32'hF8000000, "sra_res");
    expect_at(cyc + 1, K_WREG, 32'd9, "sra_wreg");
    step();

    nop(); aluOperation = 4'd9; readData1 = 32'hFFFFFFFF; readData2 = 32'h1;
    expect_at(cyc + 1, K_RES, 32'h1, "slt_res");
    step();

    nop(); aluOperation = 4'd10; readData1 = 32'hFFFFFFFF; readData2 = 32'h1;
    expect_at(cyc + 1, K_RES, 32'h0, "sltu_res");
    step();

    nop(); aluOperation = 4'd0; readData1 = 32'h4; readData2 = 32'h3;
    expect_at(cyc + 1, K_RES, 32'h30, "sll_var_res");
    step();

    nop(); aluOperation = 4'd4; readData1 = 32'd10; aluSrc = 1'b1; sigExt = 32'd3;
    fwdB = 2'd2; wbFwdData = 32'hAB; readData2 = 32'h55;
    expect_at(cyc + 1, K_RES, 32'd7, "sub_imm_res");
    expect_at(cyc + 1, K_WDATA, 32'hAB, "sub_wdata_fwdb");
    step();

    nop(); aluOperation = 4'd13; readData1 = 32'h5; readData2 = 32'h6;
    expect_at(cyc + 1, K_RES, 32'h0, "op13_res");
    step();

    nop(); aluOperation = 4'd7; loadImm = 1'b1; sigExt = 32'hFFFF1234; readData1 = 32'h1; memWrite = 4'hF;
    expect_at(cyc + 1, K_RES, 32'h12340000, "lui_res");
    expect_at(cyc + 1, K_MW, 32'hF, "lui_mw");
    step();

    // MUL 7 * -3 through forwarded A; unselected forward data changes during BUSY
    nop(); aluOperation = 4'd11; fwdA = 2'd1; memFwdData = 32'd7; readData2 = 32'hFFFFFFFD;
    regWrite = 1'b1; regDst = 1'b1; rd = 5'd5;
    k = cyc;
    expect_at(k, K_STALL0, 32'h0, "mul_dis_stall");
    expect_at(k + 1, K_RES0, 32'h0, "mul_dis_res");
    for (int i = 0; i <= 32; i++) expect_at(k + i, K_STALL, 32'h1, "mul1_stall_hi");
    for (int i = 1; i <= 33; i++) expect_at(k + i, K_RW, 32'h0, "mul1_bubble_rw");
    expect_at(k + 33, K_STALL, 32'h0, "mul1_stall_lo");
    expect_at(k + 34, K_RES, 32'hFFFFFFEB, "mul1_res");
    expect_at(k + 34, K_RW, 32'h1, "mul1_rw");
    expect_at(k + 34, K_WREG, 32'd5, "mul1_wreg");
    for (int i = 1; i <= 34; i++) begin
      step();
      if (i == 5) wbFwdData = 32'h99;
    end

    // Back-to-back MUL, product truncated to 32 bits
    nop(); aluOperation = 4'd11; fwdA = 2'd1; memFwdData = 32'h10001; readData2 = 32'h10001; regWrite = 1'b1;
    k = cyc;
    for (int i = 0; i <= 32; i++) expect_at(k + i, K_STALL, 32'h1, "mul2_stall_hi");
    expect_at(k + 33, K_STALL, 32'h0, "mul2_stall_lo");
    expect_at(k + 34, K_RES, 32'h00020001, "mul2_res");
    for (int i = 1; i <= 34; i++) step();

    // syncClr during BUSY iteration 10
    nop(); aluOperation = 4'd3; readData1 = 32'h100; readData2 = 32'h23; regDst = 1'b1; rd = 5'd4;
    regWrite = 1'b1; memReadWidth = 2'd1; memToReg = 1'b1;
    expect_at(cyc + 1, K_RES, 32'h123, "pre_clr_res");
    step();
    nop(); aluOperation = 4'd11; readData1 = 32'd3; readData2 = 32'd5; regWrite = 1'b1; memReadWidth = 2'd1;
    k = cyc;
    expect_at(k + 10, K_STALL, 32'h1, "clr_busy_stall");
    for (int i = 1; i <= 11; i++) step();
    syncClr = 1'b1;
    expect_at(cyc, K_STALL, 32'h0, "clr_stall_same");
    expect_at(cyc + 1, K_RES, 32'h0, "clr_res");
    expect_at(cyc + 1, K_WREG, 32'h0, "clr_wreg");
    expect_at(cyc + 1, K_WDATA, 32'h0, "clr_wdata");
    expect_at(cyc + 1, K_MRW, 32'h0, "clr_mrw");
    expect_at(cyc + 1, K_MTR, 32'h0, "clr_mtr");
    step();
    syncClr = 1'b0;
    nop(); aluOperation = 4'd3; readData1 = 32'd1; readData2 = 32'd2; regWrite = 1'b1; rt = 5'd6;
    expect_at(cyc, K_STALL, 32'h0, "post_clr_idle");
    expect_at(cyc + 1, K_RES, 32'd3, "post_clr_res");
    expect_at(cyc + 1, K_WREG, 32'd6, "post_clr_wreg");
    step();

    // Asynchronous reset during BUSY
    nop(); aluOperation = 4'd11; readData1 = 32'd3; readData2 = 32'd5; regWrite = 1'b1;
    k = cyc;
    expect_at(k + 4, K_STALL, 32'h1, "rst_busy_stall");
    for (int i = 1; i <= 5; i++) step();
    reset = 1'b1;
    expect_at(cyc, K_RES, 32'h0, "rst_res");
    expect_at(cyc, K_WREG, 32'h0, "rst_wreg");
    expect_at(cyc, K_STALL, 32'h0, "rst_stall");
    step();
    reset = 1'b0;
    nop(); aluOperation = 4'd3; readData1 = 32'd2; readData2 = 32'd2;
    expect_at(cyc, K_STALL, 32'h0, "post_rst_idle");
    expect_at(cyc + 1, K_RES, 32'd4, "post_rst_res");
    step();
    step();
    @(negedge clock);
    #1;
    while (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL %s never checked (cyc %0d)", sb[0].name, sb[0].cyc);
      void'(sb.pop_front());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
